// File: rtl/demux_1_8_seq_if.sv
// demux_1_8_seq_if: groups the control, data and status signals of demux_1_8_seq.
//   master modport : drives en/mode/load/din/sel/sync and observes the status outputs
//   slave modport  : the demux itself; it receives the controls and drives
//                    dout/idx/valid/wr_ack/busy
interface demux_1_8_seq_if;
    logic       en;      // block enable
    logic       mode;    // 0 = addressed demux, 1 = auto-scan deserializer
    logic       load;    // data strobe
    logic       din;     // data bit
    logic [2:0] sel;     // target bit index (addressed mode)
    logic       sync;    // restart scan word (scan mode)
    logic [7:0] dout;    // registered demultiplexed word
    logic [2:0] idx;     // next scan bit position
    logic       valid;   // one-cycle pulse: complete scan word on dout
    logic       wr_ack;  // one-cycle pulse: addressed write done
    logic       busy;    // scan word partially collected

    modport master (
        output en, mode, load, din, sel, sync,
        input  dout, idx, valid, wr_ack, busy
    );

    modport slave (
        input  en, mode, load, din, sel, sync,
        output dout, idx, valid, wr_ack, busy
    );
endinterface

// File: rtl/demux_1_8_seq.sv
// demux_1_8_seq: sequential 1:8 demultiplexer / 8-bit serial deserializer.
//   mode=0: each enabled load writes din into dout[sel] and pulses wr_ack.
//   mode=1: enabled loads collect din into a shadow register, LSB first; the
//           eighth bit transfers the whole word to dout at once and pulses valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - demux_1_8_seq_if.slave (controls in, dout/idx/valid/wr_ack/busy out)
// Parameters:
//   CLR_ON_SYNC - 1: sync also clears the shadow bits; 0: sync only rewinds idx
// All outputs are registered; nothing combinational runs from input to output.
module demux_1_8_seq #(
    parameter bit CLR_ON_SYNC = 1'b1
) (
    input logic            clk,
    input logic            rst,
    demux_1_8_seq_if.slave bus
);

    typedef enum logic {
        StIdle,
        StCollect
    } state_e;

    state_e     state;
    logic [2:0] idx;
    // Holds bits 0..6 of the word being collected; bit 7 comes straight from din
    // on the completing edge, so it never needs storage.
    logic [6:0] shadow;
    logic [7:0] dout;
    logic       valid;
    logic       wr_ack;
    logic       busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            idx    <= 3'd0;
            shadow <= 7'd0;
            dout   <= 8'h00;
            valid  <= 1'b0;
            wr_ack <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // Pulses are one cycle wide unless re-asserted below.
            valid  <= 1'b0;
            wr_ack <= 1'b0;

            if (!bus.mode) begin
                // Addressed mode: any partial scan word is dropped, regardless of en.
                state <= StIdle;
                idx   <= 3'd0;
                busy  <= 1'b0;
                if (bus.en && bus.load) begin
                    dout[bus.sel] <= bus.din;
                    wr_ack        <= 1'b1;
                end
            end else if (bus.en) begin
                if (bus.sync) begin
                    // sync beats a coincident load: the bit is discarded.
                    state <= StIdle;
                    idx   <= 3'd0;
                    busy  <= 1'b0;
                    if (CLR_ON_SYNC) begin
                        shadow <= 7'd0;
                    end
                end else if (bus.load) begin
                    unique case (state)
                        StIdle: begin
                            shadow[0] <= bus.din;
                            idx       <= 3'd1;
                            busy      <= 1'b1;
                            state     <= StCollect;
                        end
                        StCollect: begin
                            if (idx == 3'd7) begin
                                dout  <= {bus.din, shadow};
                                idx   <= 3'd0;
                                busy  <= 1'b0;
                                valid <= 1'b1;
                                state <= StIdle;
                            end else begin
                                shadow[idx] <= bus.din;
                                idx         <= idx + 3'd1;
                                busy        <= 1'b1;
                            end
                        end
                        default: begin
                            state <= StIdle;
                            idx   <= 3'd0;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
            // en=0 in scan mode: everything holds, so collection resumes where it paused.
        end
    end

    assign bus.dout   = dout;
    assign bus.idx    = idx;
    assign bus.valid  = valid;
    assign bus.wr_ack = wr_ack;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_demux_1_8_seq.sv
// Self-checking bench for demux_1_8_seq. Expected scan words and expected
// post-write dout values are queued when stimulus is driven; a monitor pops and
// compares them whenever valid or wr_ack pulses.
module tb_demux_1_8_seq;

    logic clk = 1'b0;
    logic rst;

    demux_1_8_seq_if bus ();

    demux_1_8_seq #(
        .CLR_ON_SYNC(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int valid_count = 0;
    int ack_count   = 0;

    logic [7:0] word_q[$];
    logic [7:0] ack_q[$];

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (bus.valid === 1'b1) begin
            valid_count++;
            checks++;
            if (word_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid dout=%h (no word expected)", bus.dout);
            end else begin
                exp = word_q.pop_front();
                if (bus.dout !== exp) begin
                    errors++;
                    $display("FAIL scan_word got %h want %h", bus.dout, exp);
                end
            end
        end
        if (bus.wr_ack === 1'b1) begin
            ack_count++;
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_ack dout=%h (no write expected)", bus.dout);
            end else begin
                exp = ack_q.pop_front();
                if (bus.dout !== exp) begin
                    errors++;
                    $display("FAIL write_result got %h want %h", bus.dout, exp);
                end
            end
        end
    end

    // One active edge, then settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift n bits of value, starting at bit 'first', LSB first, load held high.
    task automatic scan_bits(input logic [7:0] value, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.din  = value[i];
            bus.load = 1'b1;
            tick();
        end
        bus.load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must win over every control on the same edge.
        bus.en = 1'b1; bus.mode = 1'b1; bus.load = 1'b1; bus.sync = 1'b1; bus.din = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.load = 1'b0; bus.sync = 1'b0;
        checks++; if (bus.dout !== 8'h00) begin errors++;
            $display("FAIL reset_dout got %h want 00", bus.dout); end
        checks++; if (bus.idx !== 3'd0) begin errors++;
            $display("FAIL reset_idx got %0d want 0", bus.idx); end
        checks++; if (bus.valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (bus.wr_ack !== 1'b0) begin errors++;
            $display("FAIL reset_wr_ack got %b want 0", bus.wr_ack); end
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_scan_word();
        int v0;
        v0 = valid_count;
        bus.mode = 1'b1; bus.en = 1'b1;
        scan_bits(8'h93, 0, 4);
        checks++; if (bus.idx !== 3'd4 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL scan_partial_idx got idx=%0d busy=%b want idx=4 busy=1",
                     bus.idx, bus.busy); end
        checks++; if (bus.dout !== 8'h00) begin errors++;
            $display("FAIL scan_partial_hidden got %h want 00", bus.dout); end
        word_q.push_back(8'h93);
        scan_bits(8'h93, 4, 4);
        checks++; if (bus.idx !== 3'd0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL scan_end_idx got idx=%0d busy=%b want idx=0 busy=0",
                     bus.idx, bus.busy); end
        tick();
        checks++; if (valid_count - v0 != 1 || bus.valid !== 1'b0) begin errors++;
            $display("FAIL scan_valid_pulse got %0d pulses valid=%b want 1 pulse valid=0",
                     valid_count - v0, bus.valid); end
    endtask

    task automatic test_addressed();
        int v0;
        int a0;
        do_reset();
        v0 = valid_count; a0 = ack_count;
        bus.mode = 1'b0; bus.en = 1'b1;
        bus.sync = 1'b1; // don't-care in addressed mode
        bus.sel = 3'd3; bus.din = 1'b1; bus.load = 1'b1;
        ack_q.push_back(8'h08);
        tick();
        bus.load = 1'b0;
        checks++; if (bus.wr_ack !== 1'b1) begin errors++;
            $display("FAIL wr_ack_first got %b want 1", bus.wr_ack); end
        tick();
        checks++; if (bus.wr_ack !== 1'b0) begin errors++;
            $display("FAIL wr_ack_single got %b want 0", bus.wr_ack); end
        bus.sel = 3'd7; bus.din = 1'b1; bus.load = 1'b1;
        ack_q.push_back(8'h88);
        tick();
        bus.load = 1'b0; bus.sync = 1'b0;
        tick();
        checks++; if (bus.dout !== 8'h88 || bus.idx !== 3'd0) begin errors++;
            $display("FAIL addr_result got dout=%h idx=%0d want dout=88 idx=0",
                     bus.dout, bus.idx); end
        // Clear a bit again; other bits must hold.
        bus.sel = 3'd3; bus.din = 1'b0; bus.load = 1'b1;
        ack_q.push_back(8'h80);
        tick();
        bus.load = 1'b0;
        tick();
        checks++; if (ack_count - a0 != 3 || valid_count != v0) begin errors++;
            $display("FAIL addr_pulses got acks=%0d valids=%0d want acks=3 valids=0",
                     ack_count - a0, valid_count - v0); end
    endtask

    task automatic test_enable_gap();
        do_reset();
        bus.mode = 1'b1; bus.en = 1'b1;
        scan_bits(8'h5A, 0, 4);
        bus.en = 1'b0; bus.load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = i[0];
            tick();
            checks++; if (bus.idx !== 3'd4 || bus.busy !== 1'b1 || bus.dout !== 8'h00) begin
                errors++;
                $display("FAIL gap_hold got idx=%0d busy=%b dout=%h want idx=4 busy=1 dout=00",
                         bus.idx, bus.busy, bus.dout);
            end
        end
        bus.load = 1'b0; bus.en = 1'b1;
        word_q.push_back(8'h5A);
        scan_bits(8'h5A, 4, 4);
        tick();
        checks++; if (bus.dout !== 8'h5A) begin errors++;
            $display("FAIL gap_word got %h want 5a", bus.dout); end
    endtask

    task automatic test_sync_collision();
        int v0;
        do_reset();
        v0 = valid_count;
        bus.mode = 1'b1; bus.en = 1'b1;
        scan_bits(8'h07, 0, 3);
        bus.sync = 1'b1; bus.load = 1'b1; bus.din = 1'b1;
        tick();
        bus.sync = 1'b0; bus.load = 1'b0;
        checks++; if (bus.idx !== 3'd0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL sync_restart got idx=%0d busy=%b want idx=0 busy=0",
                     bus.idx, bus.busy); end
        word_q.push_back(8'hA5);
        scan_bits(8'hA5, 0, 8);
        tick();
        checks++; if (bus.dout !== 8'hA5 || valid_count - v0 != 1) begin errors++;
            $display("FAIL sync_word got dout=%h pulses=%0d want dout=a5 pulses=1",
                     bus.dout, valid_count - v0); end
    endtask

    task automatic test_reset_mid_word();
        int v0;
        v0 = valid_count;
        // dout holds a5 from the previous word, so the clear is observable.
        scan_bits(8'h1F, 0, 5);
        bus.load = 1'b1; bus.din = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.load = 1'b0;
        checks++; if (bus.dout !== 8'h00 || bus.idx !== 3'd0) begin errors++;
            $display("FAIL rst_mid got dout=%h idx=%0d want dout=00 idx=0", bus.dout, bus.idx); end
        tick();
        checks++; if (valid_count != v0) begin errors++;
            $display("FAIL rst_mid_valid got %0d pulses want 0", valid_count - v0); end
        word_q.push_back(8'hC3);
        scan_bits(8'hC3, 0, 8);
        tick();
        checks++; if (bus.dout !== 8'hC3) begin errors++;
            $display("FAIL rst_mid_word got %h want c3", bus.dout); end
    endtask

    task automatic test_mode_switch();
        scan_bits(8'hFF, 0, 6);
        bus.mode = 1'b0;
        tick();
        checks++; if (bus.idx !== 3'd0 || bus.busy !== 1'b0 || bus.dout !== 8'hC3) begin
            errors++;
            $display("FAIL mode_discard got idx=%0d busy=%b dout=%h want idx=0 busy=0 dout=c3",
                     bus.idx, bus.busy, bus.dout);
        end
        bus.mode = 1'b1;
        word_q.push_back(8'h3C);
        scan_bits(8'h3C, 0, 8);
        tick();
        checks++; if (bus.dout !== 8'h3C) begin errors++;
            $display("FAIL mode_word got %h want 3c", bus.dout); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_count;
        word_q.push_back(8'h12);
        word_q.push_back(8'hEF);
        for (int w = 0; w < 2; w++) begin
            logic [7:0] val;
            val = (w == 0) ? 8'h12 : 8'hEF;
            for (int i = 0; i < 8; i++) begin
                bus.din  = val[i];
                bus.load = 1'b1;
                tick();
            end
        end
        bus.load = 1'b0;
        tick();
        checks++; if (bus.dout !== 8'hEF || valid_count - v0 != 2) begin errors++;
            $display("FAIL b2b_words got dout=%h pulses=%0d want dout=ef pulses=2",
                     bus.dout, valid_count - v0); end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 1'b0; bus.load = 1'b0;
        bus.din = 1'b0; bus.sel = 3'd0; bus.sync = 1'b0;
        tick();
        test_reset();
        test_scan_word();
        test_addressed();
        test_enable_gap();
        test_sync_collision();
        test_reset_mid_word();
        test_mode_switch();
        test_back_to_back();
        tick();
        checks++; if (word_q.size() != 0 || ack_q.size() != 0) begin errors++;
            $display("FAIL scoreboard_drain got words=%0d acks=%0d left want 0",
                     word_q.size(), ack_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_8_seq.md
DEMUX_1_8_SEQ -- requirements
Module: demux_1_8_seq

Interface
REQ-001 Parameter: CLR_ON_SYNC, default 1, meaning: 1 = sync clears shadow bits; 0 = sync clears index only.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  synchronous, active-high reset; one clock, synchronous, active-high reset is fixed for this block.
REQ-004 en  input  1  block enable; when 0, load and sync are ignored.
REQ-005 mode  input  1  0 = addressed demux, 1 = auto-scan deserializer.
REQ-006 load  input  1  data strobe; din is sampled on a clk edge where en=1 and load=1.
REQ-007 din  input  1  serial/single data bit.
REQ-008 sel  input  3  target bit index, mode=0 only.
REQ-009 sync  input  1  restart scan word, mode=1 only.
REQ-010 dout  output  8  registered demultiplexed word.
REQ-011 idx  output  3  current scan index, equal to the next bit position to be written.
REQ-012 valid  output  1  one-cycle pulse: a complete scan word is present on dout.
REQ-013 wr_ack  output  1  one-cycle pulse: an addressed write has completed.
REQ-014 busy  output  1  1 while a scan word is partially collected (idx != 0).

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 Addressed mode (mode=0, en=1, load=1): SHALL set dout[sel] <= din and hold all other dout bits.
REQ-017 Addressed mode: SHALL assert wr_ack for exactly the cycle after the write edge.
REQ-018 Addressed mode: valid SHALL stay 0.
REQ-019 While mode=0, idx SHALL be forced to 0 each clock.
REQ-020 Scan FSM states: IDLE (idx=0) and COLLECT (idx 1..7).
REQ-021 IDLE + load: shadow[0] <= din, idx <= 1, go to COLLECT.
REQ-022 COLLECT + load with idx<7: shadow[idx] <= din, idx <= idx+1.
REQ-023 COLLECT + load with idx=7: dout <= {din, shadow[6:0]} atomically, idx wraps to 0, go to IDLE, assert valid for the following cycle only.
REQ-024 Scan mode: dout SHALL change only on word completion; partial words are never visible on dout.
REQ-025 Bit order: the first bit collected after IDLE lands in dout[0] and the eighth in dout[7], matching the 8:1 mux sel scan order 0..7.
REQ-026 Load with en=0: SHALL be ignored; idx, shadow and dout hold; no valid or wr_ack pulse.
REQ-027 en deasserted mid-word: collection SHALL pause without loss and resume at the same idx.
REQ-028 sync=1 (en=1, mode=1): idx <= 0 and state <= IDLE; if CLR_ON_SYNC=1, shadow <= 0; dout is unchanged.
REQ-029 sync and load on the same edge: sync SHALL win, the bit is discarded, and no valid pulse occurs.
REQ-030 mode toggling 1->0 mid-word: the partial word SHALL be discarded (idx forced 0); dout is unchanged.
REQ-031 busy SHALL equal (idx != 0), registered.
REQ-032 sel and sync SHALL be don't-care in the mode where they are unused.

Reset
REQ-033 rst=1 at a clk edge SHALL give: dout=8'h00, idx=0, shadow=0, valid=0, wr_ack=0, busy=0, state IDLE.
REQ-034 rst SHALL override en, load, sync and mode on the same edge.
REQ-035 Reset mid-word SHALL discard the partial word with no valid pulse.

Verification
REQ-036 Scan word: mode=1, en=1, 8 consecutive loads with din=1,1,0,0,1,0,0,1 -> dout=8'h93, one valid pulse one cycle after the 8th load, then idx=0 and busy=0.
REQ-037 Addressed writes: mode=0, writes of (sel=3,din=1) then (sel=7,din=1) starting from reset -> dout=8'h88; wr_ack pulses once per write; valid stays 0.
REQ-038 Enable gap: scan 4 bits, en=0 for 5 cycles with load=1, then 4 more bits -> dout equals the 8 bits sent while en=1; idx=4 held during the gap.
REQ-039 Sync collision: scan 3 bits, then sync=1 and load=1 on the same edge, then 8 bits of 8'hA5 LSB-first -> dout=8'hA5 with exactly one valid pulse.
REQ-040 Reset mid-word: scan 5 bits, rst=1 for one cycle -> dout=8'h00, idx=0, no valid pulse; the next 8 bits form a full word.
REQ-041 Mode switch: scan 6 bits, set mode=0 for one cycle, return to mode=1, send 8 bits of 8'h3C -> dout=8'h3C; the earlier 6 bits never appear on dout.
